// File: rtl/timer_ctrl.sv
// timer_ctrl: square-wave / PWM sequencer with a valid/ready shadow config register.
// New configurations reach the active registers only when the controller is idle, or on
// the last phase of a period while running, so the output never glitches.
// Optional build macro TIMER_CTRL_IRQ_EN adds a sticky irq output and an irq_clr input.
module timer_ctrl #(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned PCNT_W     = 8,
  parameter int unsigned DEF_PERIOD = 40,
  parameter int unsigned DEF_HIGH   = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic [CNT_W-1:0]  cfg_high,
  input  logic [PCNT_W-1:0] cfg_count,
  input  logic              start,
  input  logic              stop,
  output logic              wave,
  output logic              busy,
  output logic              done,
  output logic [PCNT_W-1:0] pulse_idx
`ifdef TIMER_CTRL_IRQ_EN
  ,
  output logic              irq,
  input  logic              irq_clr
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state;
  logic [CNT_W-1:0]    phase;
  logic                pending;
  logic [CNT_W-1:0]    act_period, act_high, sh_period, sh_high;
  logic [PCNT_W-1:0]   act_count, sh_count;
  logic [CNT_W-1:0]    san_period, san_high;
  logic                last_phase, last_pulse;

  assign cfg_ready = !pending;

  // Clamp the offered config so the active period is at least 2 and high < period.
  always_comb begin
    san_period = (cfg_period < CNT_W'(2)) ? CNT_W'(2) : cfg_period;
    san_high   = (cfg_high >= san_period) ? san_period - CNT_W'(1) : cfg_high;
  end

  // Period boundary and final-pulse detection for the running train.
  always_comb begin
    last_phase = (phase == act_period - CNT_W'(1));
    last_pulse = (act_count != '0) && (pulse_idx == act_count - PCNT_W'(1));
  end

  // Control FSM, shadow/active config registers and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      phase      <= '0;
      pending    <= 1'b0;
      act_period <= CNT_W'(DEF_PERIOD);
      act_high   <= CNT_W'(DEF_HIGH);
      act_count  <= '0;
      sh_period  <= '0;
      sh_high    <= '0;
      sh_count   <= '0;
      wave       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pulse_idx  <= '0;
    end else begin
      done <= 1'b0;
      // Transfer and copy are mutually exclusive: one needs pending low, the other high.
      if (cfg_valid && !pending) begin
        sh_period <= san_period;
        sh_high   <= san_high;
        sh_count  <= cfg_count;
        pending   <= 1'b1;
      end
      case (state)
        IDLE: begin
          wave <= 1'b0;
          busy <= 1'b0;
          if (pending) begin
            act_period <= sh_period;
            act_high   <= sh_high;
            act_count  <= sh_count;
            pending    <= 1'b0;
          end else if (start && !stop) begin
            state     <= RUN;
            busy      <= 1'b1;
            phase     <= '0;
            pulse_idx <= '0;
            wave      <= (act_high != '0);
          end
        end
        RUN: begin
          if (last_phase) begin
            phase <= '0;
            if (pending) begin
              act_period <= sh_period;
              act_high   <= sh_high;
              act_count  <= sh_count;
              pending    <= 1'b0;
              pulse_idx  <= '0;
            end
          end else begin
            phase <= phase + CNT_W'(1);
          end
          // A boundary copy restarts the train, so it takes precedence over completion.
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
            wave  <= 1'b0;
          end else if (last_phase && pending) begin
            wave <= (sh_high != '0);
          end else if (last_phase && last_pulse) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            wave  <= 1'b0;
          end else if (last_phase) begin
            pulse_idx <= pulse_idx + PCNT_W'(1);
            wave      <= (act_high != '0);
          end else begin
            wave <= ((phase + CNT_W'(1)) < act_high);
          end
        end
        DONE: begin
          wave  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
          if (pending) begin
            act_period <= sh_period;
            act_high   <= sh_high;
            act_count  <= sh_count;
            pending    <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TIMER_CTRL_IRQ_EN
  // Sticky completion flag; a new done wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         irq <= 1'b0;
    else if (done)    irq <= 1'b1;
    else if (irq_clr) irq <= 1'b0;
  end
`endif

endmodule
